// File: rtl/serial_feeder_pkg.sv
// Shared definitions for the console serial feeder and its future receive-side monitor.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package serial_feeder_pkg;

  // Transmit FSM encoding, shared with the receive-side monitor.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_GAP   = 3'd4
  } state_t;

  // Carriage return: the byte that earns the long end-of-line gap.
  localparam logic [7:0] CR_BYTE = 8'h0D;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Byte FIFO, depth 2**AW, with registered full/empty and occupancy count.
// Latency: a pushed byte is visible at o_data (head) the cycle after the push.
// Backpressure: pushes while full are silently dropped; pops while empty are ignored.
module sync_fifo #(
  parameter int AW = 4
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_wr,
  input  logic [7:0]    i_data,
  input  logic          i_rd,
  output logic [7:0]    o_data,
  output logic          o_full,
  output logic          o_empty,
  output logic [AW:0]   o_count
);

  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_full;
  logic          r_empty;

  logic          w_push;
  logic          w_pop;
  logic [AW:0]   w_count_nxt;

  // A write is accepted only against the registered full flag, even when a pop frees a slot.
  assign w_push = i_wr & ~r_full;
  assign w_pop  = i_rd & ~r_empty;

  // Next occupancy: push and pop together leave it unchanged.
  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop) begin
      w_count_nxt = r_count + CNT_ONE;
    end else if (w_pop && !w_push) begin
      w_count_nxt = r_count - CNT_ONE;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointers, count and flags; pointers wrap naturally at the depth.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CNT_FULL);
      r_empty <= (w_count_nxt == '0);
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_full  = r_full;
  assign o_empty = r_empty;
  assign o_count = r_count;

endmodule

// File: rtl/serial_feeder.sv
// Buffered 8N1 transmitter with per-character and end-of-line idle gaps.
// Latency: push into an empty idle FIFO to tx falling is 2 clocks; frame is 10*CLKS_PER_BIT.
// Backpressure: i_hold pauses between frames only; pushes while full are dropped.
module serial_feeder
  import serial_feeder_pkg::*;
#(
  parameter int CLKS_PER_BIT = 217,
  parameter int FIFO_AW      = 4,
  parameter int CHAR_GAP     = 0,
  parameter int EOL_GAP      = 250000
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_wr,
  input  logic [7:0]         i_data_in,
  input  logic               i_hold,
  output logic               o_tx,
  output logic               o_full,
  output logic               o_empty,
  output logic [FIFO_AW:0]   o_count,
  output logic               o_busy
);

  localparam int BW      = $clog2(CLKS_PER_BIT);
  localparam int GAP_MAX = max_int(EOL_GAP, CHAR_GAP);
  localparam int GW      = ($clog2(GAP_MAX + 1) < 1) ? 1 : $clog2(GAP_MAX + 1);

  localparam logic [BW-1:0] BIT_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_ONE  = BW'(1);
  localparam logic [GW-1:0] GAP_CHR  = GW'(CHAR_GAP);
  localparam logic [GW-1:0] GAP_EOL  = GW'(EOL_GAP);
  localparam logic [GW-1:0] GAP_ONE  = GW'(1);

  state_t        r_state;
  logic [7:0]    r_sh;
  logic [2:0]    r_bit;
  logic [BW-1:0] r_timer;
  logic [GW-1:0] r_gap;
  logic          r_is_cr;
  logic          r_tx;

  state_t        w_state_nxt;
  logic [7:0]    w_sh_nxt;
  logic [2:0]    w_bit_nxt;
  logic [BW-1:0] w_timer_nxt;
  logic [GW-1:0] w_gap_nxt;
  logic          w_is_cr_nxt;
  logic          w_tx_nxt;
  logic          w_pop;
  logic          w_bit_end;
  logic [7:0]    w_head;
  logic          w_empty;

  sync_fifo #(.AW(FIFO_AW)) u_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_wr    (i_wr),
    .i_data  (i_data_in),
    .i_rd    (w_pop),
    .o_data  (w_head),
    .o_full  (o_full),
    .o_empty (w_empty),
    .o_count (o_count)
  );

  assign w_bit_end = (r_timer == '0);

  // Next-state, shifter, timers and the line level that the next state will drive.
  always_comb begin
    w_state_nxt = r_state;
    w_sh_nxt    = r_sh;
    w_bit_nxt   = r_bit;
    w_timer_nxt = r_timer;
    w_gap_nxt   = r_gap;
    w_is_cr_nxt = r_is_cr;
    w_pop       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty && !i_hold) begin
          w_pop       = 1'b1;
          w_sh_nxt    = w_head;
          w_is_cr_nxt = (w_head == CR_BYTE);
          w_timer_nxt = BIT_LAST;
          w_state_nxt = ST_START;
        end
      end
      ST_START: begin
        if (w_bit_end) begin
          w_timer_nxt = BIT_LAST;
          w_bit_nxt   = 3'd0;
          w_state_nxt = ST_DATA;
        end else begin
          w_timer_nxt = r_timer - BIT_ONE;
        end
      end
      ST_DATA: begin
        if (w_bit_end) begin
          w_timer_nxt = BIT_LAST;
          w_sh_nxt    = {1'b0, r_sh[7:1]};
          if (r_bit == 3'd7) begin
            w_state_nxt = ST_STOP;
          end else begin
            w_bit_nxt = r_bit + 3'd1;
          end
        end else begin
          w_timer_nxt = r_timer - BIT_ONE;
        end
      end
      ST_STOP: begin
        if (w_bit_end) begin
          w_gap_nxt   = r_is_cr ? GAP_EOL : GAP_CHR;
          w_state_nxt = ST_GAP;
        end else begin
          w_timer_nxt = r_timer - BIT_ONE;
        end
      end
      ST_GAP: begin
        // A gap of N idles N cycles here; N=0 still costs the one pass-through cycle.
        if (r_gap <= GAP_ONE) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_gap_nxt = r_gap - GAP_ONE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    case (w_state_nxt)
      ST_START: w_tx_nxt = 1'b0;
      ST_DATA:  w_tx_nxt = w_sh_nxt[0];
      default:  w_tx_nxt = 1'b1;
    endcase
  end

  // Registered FSM state and datapath; tx is a flop so the line never glitches.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
      r_sh    <= '0;
      r_bit   <= '0;
      r_timer <= '0;
      r_gap   <= '0;
      r_is_cr <= 1'b0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_sh    <= w_sh_nxt;
      r_bit   <= w_bit_nxt;
      r_timer <= w_timer_nxt;
      r_gap   <= w_gap_nxt;
      r_is_cr <= w_is_cr_nxt;
      r_tx    <= w_tx_nxt;
    end
  end

  assign o_tx    = r_tx;
  assign o_empty = w_empty;
  assign o_busy  = (r_state != ST_IDLE);

endmodule

// File: tb/tb_serial_feeder.sv
// Randomized bench for serial_feeder against a queue-and-timeline reference model.
// Latency: model predicts pops from frame length and gap rules, checked every cycle.
// Backpressure: exercises full drops, hold between frames and reset mid-frame.
module tb_serial_feeder;

  localparam int CPB   = 4;
  localparam int AW    = 4;
  localparam int CG    = 0;
  localparam int EG    = 20;
  localparam int DEPTH = 16;
  localparam int FRAME = 10 * CPB;

  logic          clk;
  logic          rst;
  logic          wr;
  logic          hold;
  logic [7:0]    din;
  logic          tx;
  logic          full;
  logic          empty;
  logic          busy;
  logic [AW:0]   count;

  serial_feeder #(
    .CLKS_PER_BIT(CPB), .FIFO_AW(AW), .CHAR_GAP(CG), .EOL_GAP(EG)
  ) dut (
    .i_clk(clk), .i_reset(rst), .i_wr(wr), .i_data_in(din), .i_hold(hold),
    .o_tx(tx), .o_full(full), .o_empty(empty), .o_count(count), .o_busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: byte queue plus a timeline of when the line is free again.
  int         cyc = 0;
  int         occ = 0;
  int         idle_from = 0;
  int         busy_last = -1;
  int         m_g;
  logic       m_push;
  logic       m_pop;
  logic [7:0] m_b;
  logic [7:0] q[$];
  logic [7:0] sent_q[$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      sent_q.delete();
      occ       = 0;
      idle_from = 0;
      busy_last = -1;
    end else begin
      cyc++;
      m_pop  = (cyc >= idle_from) && (occ > 0) && !hold;
      m_push = wr && (occ < DEPTH);
      if (m_pop) begin
        m_b = q.pop_front();
        sent_q.push_back(m_b);
        m_g = (m_b == 8'h0D) ? EG : CG;
        if (m_g < 1) m_g = 1;
        busy_last = cyc + FRAME - 1 + m_g;
        idle_from = cyc + FRAME + 1 + m_g;
      end
      if (m_push) q.push_back(din);
      occ = occ + int'(m_push) - int'(m_pop);
    end
  end

  // Every cycle: FIFO status and busy against the model.
  always @(negedge clk) begin
    if (!rst) begin
      check("count", 32'(count), 32'(occ));
      check("full",  32'(full),  32'(occ == DEPTH));
      check("empty", 32'(empty), 32'(occ == 0));
      check("busy",  32'(busy),  32'(cyc <= busy_last));
    end
  end

  // Line receiver: mid-bit sampling of 8N1 frames.
  int         k = -1;
  logic [9:0] fr;
  logic [9:0] last_fr;
  int         falls[$];
  logic [7:0] rx_log[$];

  always @(negedge clk) begin
    if (rst) begin
      k = -1;
    end else if (k < 0) begin
      if (tx == 1'b0) begin
        k = 0;
        falls.push_back(cyc);
      end
    end else begin
      k++;
      if ((k - 1) % CPB == 0) begin
        fr[(k - 1) / CPB] = tx;
        if ((k - 1) / CPB == 9) begin
          k = -1;
          last_fr = fr;
          rx_log.push_back(fr[8:1]);
          check("start_bit", 32'(fr[0]), 32'd0);
          check("stop_bit",  32'(fr[9]), 32'd1);
          check("rx_expected", 32'(sent_q.size() != 0), 32'd1);
          if (sent_q.size() != 0) check("rx_byte", 32'(fr[8:1]), 32'(sent_q.pop_front()));
        end
      end
    end
  end

  task automatic push(input logic [7:0] b);
    din = b;
    wr  = 1'b1;
    @(negedge clk);
    wr  = 1'b0;
  endtask

  task automatic drain(input string tag, input int max_cyc);
    int n;
    n = 0;
    @(negedge clk);
    while (!(empty && !busy && k < 0 && occ == 0) && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_timeout"}, 32'(n >= max_cyc), 32'd0);
  endtask

  int n0;
  int busy_cnt;
  int nb;
  int w;

  initial begin
    rst = 1'b0; wr = 1'b0; hold = 1'b0; din = 8'h00;
    #1 rst = 1'b1;
    #1;
    check("rst_tx",    32'(tx),    32'd1);
    check("rst_count", 32'(count), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full",  32'(full),  32'd0);
    check("rst_busy",  32'(busy),  32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Single byte: latency, line pattern, busy length.
    falls.delete();
    n0 = cyc;
    push(8'h55);
    busy_cnt = 0;
    for (int i = 0; i < 60; i++) begin
      if (busy) busy_cnt++;
      @(negedge clk);
    end
    drain("t1", 200);
    check("t1_falls", 32'(falls.size()), 32'd1);
    if (falls.size() > 0) check("t1_latency", 32'(falls[0] - n0), 32'd2);
    check("t1_frame", 32'(last_fr), 32'({1'b1, 8'h55, 1'b0}));
    check("t1_busy_len", 32'(busy_cnt), 32'(FRAME + 1));

    // Fill under hold, drop at full, release with a simultaneous push.
    rx_log.delete();
    hold = 1'b1;
    for (int i = 0; i < 16; i++) push(8'(i));
    check("t2_full",  32'(full),  32'd1);
    check("t2_count", 32'(count), 32'd16);
    push(8'hAA);
    check("t2_drop_count", 32'(count), 32'd16);
    din = 8'hBB; wr = 1'b1; hold = 1'b0;
    @(negedge clk);
    wr = 1'b0;
    check("t2_pop_at_full", 32'(count), 32'd15);
    drain("t2", 1200);
    check("t2_rx_len", 32'(rx_log.size()), 32'd16);
    for (int i = 0; i < 16; i++)
      if (i < rx_log.size()) check("t2_rx_seq", 32'(rx_log[i]), 32'(i));
    check("t2_empty", 32'(empty), 32'd1);

    // Gap after CR versus an ordinary character.
    falls.delete();
    push(8'h0D); push(8'h0A);
    drain("t3a", 300);
    check("t3a_falls", 32'(falls.size()), 32'd2);
    if (falls.size() == 2) check("t3_cr_gap", 32'(falls[1] - falls[0] - FRAME), 32'(EG + 1));
    falls.delete();
    push(8'h41); push(8'h42);
    drain("t3b", 300);
    check("t3b_falls", 32'(falls.size()), 32'd2);
    if (falls.size() == 2) check("t3_chr_gap", 32'(falls[1] - falls[0] - FRAME), 32'd2);

    // Hold asserted mid-data with a second byte queued.
    falls.delete();
    rx_log.delete();
    push(8'h3C); push(8'h77);
    w = 0;
    while (falls.size() == 0 && w < 20) begin @(negedge clk); w++; end
    check("t4_start_timeout", 32'(w >= 20), 32'd0);
    repeat (14) @(negedge clk);
    hold = 1'b1;
    repeat (100) @(negedge clk);
    check("t4_hold_busy",  32'(busy),  32'd0);
    check("t4_hold_count", 32'(count), 32'd1);
    check("t4_hold_tx",    32'(tx),    32'd1);
    n0 = cyc;
    hold = 1'b0;
    drain("t4", 200);
    check("t4_falls", 32'(falls.size()), 32'd2);
    if (falls.size() == 2) check("t4_restart", 32'(falls[1] - n0), 32'd1);
    if (rx_log.size() > 0) check("t4_first", 32'(rx_log[0]), 32'h3C);

    // Reset during bit 3 with bytes queued.
    falls.delete();
    for (int i = 0; i < 5; i++) push(8'($urandom));
    w = 0;
    while (falls.size() == 0 && w < 20) begin @(negedge clk); w++; end
    check("t5_start_timeout", 32'(w >= 20), 32'd0);
    repeat (17) @(negedge clk);
    rst = 1'b1;
    #1;
    check("t5_tx",    32'(tx),    32'd1);
    check("t5_count", 32'(count), 32'd0);
    check("t5_empty", 32'(empty), 32'd1);
    check("t5_busy",  32'(busy),  32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rx_log.delete();
    push(8'hC3);
    drain("t5", 200);
    check("t5_rx_len", 32'(rx_log.size()), 32'd1);
    if (rx_log.size() > 0) check("t5_rx", 32'(rx_log[0]), 32'hC3);

    // Random traffic with random hold toggling.
    for (int r = 0; r < 6; r++) begin
      nb = $urandom_range(1, 8);
      for (int j = 0; j < nb; j++) begin
        hold = ($urandom_range(0, 3) == 0);
        push(($urandom_range(0, 5) == 0) ? 8'h0D : 8'($urandom));
        repeat ($urandom_range(0, 30)) @(negedge clk);
      end
      hold = 1'b0;
      drain("rand", 2000);
    end

    check("sent_left", 32'(sent_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/serial_feeder.md
Name: serial_feeder

Overview:
- Host-side serial transmitter for the Altair console link: the terminal end of the 6850 serial line.
- Buffers bytes pushed by a loader or keyboard source and shifts them out as 8N1 frames on the line into the machine's rx pin.
- Adds a programmable inter-character gap and a longer end-of-line gap after CR, so 4K BASIC can absorb pasted program text without dropping characters.
- Sits in the board top beside the machine; its tx drives the machine rx.

Parameters:
- CLKS_PER_BIT, 217, clk cycles per bit time (25 MHz / 115200); must be >= 2.
- FIFO_AW, 4, FIFO address width; depth = 2**FIFO_AW = 16 entries.
- CHAR_GAP, 0, extra idle (mark) clk cycles after every stop bit.
- EOL_GAP, 250000, extra idle clk cycles after a frame whose data was 8'h0D; replaces CHAR_GAP for that frame.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  asynchronous, active-high reset.
- wr  in  1  push strobe; one byte per cycle while high.
- data_in  in  8  byte to push, sampled when wr=1.
- hold  in  1  flow-control pause; sampled only in IDLE.
- tx  out  1  serial line, idle high.
- full  out  1  FIFO holds 2**FIFO_AW bytes.
- empty  out  1  FIFO holds 0 bytes.
- count  out  FIFO_AW+1  FIFO occupancy, 0..2**FIFO_AW.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset (async assert): tx=1, full=0, empty=1, count=0, busy=0, FSM=IDLE, FIFO pointers=0, bit counter and timer=0. FIFO storage contents are not reset.
- FIFO push:
  - A push occurs when wr=1 and the registered full=0.
  - When full=1, the write is silently dropped, including on a cycle where a pop also occurs.
  - Pointers wrap modulo depth.
  - count is updated in the same clock: +1 push only, -1 pop only, unchanged on push+pop.
  - full and empty are registered and derived from the next value of count.
- FSM: IDLE -> START -> DATA -> STOP -> GAP -> IDLE.
  - IDLE: tx=1. If empty=0 and hold=0, pop the head byte into shift register sh and enter START. Pop and the transition happen in the same cycle. tx goes low on the following cycle, so latency from the first push into an empty FIFO to tx falling is 2 clocks.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA with bit index 0.
  - DATA: tx=sh[0], LSB first. Each bit lasts CLKS_PER_BIT cycles, then sh shifts right. After bit 7, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. Load the gap timer with EOL_GAP if the frame byte was 8'h0D, else CHAR_GAP.
  - GAP: tx=1 until the timer expires, then IDLE. A gap value of 0 passes through GAP in exactly one cycle.
- Frame timing: START + 8 DATA + STOP = exactly 10*CLKS_PER_BIT cycles. Back-to-back frames with CHAR_GAP=0 are separated by 2 idle cycles (the GAP and IDLE cycles).
- hold:
  - hold=1 mid-frame has no effect; the frame and its gap complete.
  - hold is re-checked only in IDLE; deasserting it restarts transmission on the next IDLE cycle.
- Bit timer: counts CLKS_PER_BIT-1 down to 0 and reloads on each bit boundary. Width is $clog2(CLKS_PER_BIT). The gap timer width is $clog2(max(EOL_GAP, CHAR_GAP)+1).
- Reset mid-frame: tx returns high immediately (async). Bytes still queued in the FIFO are discarded.
- busy=1 from the IDLE->START cycle until the return to IDLE.

Decomposition:
- A shared package holds the FSM state encoding (IDLE, START, DATA, STOP, GAP as a 3-bit localparam enum) and the CR constant 8'h0D, reused by the future receive-side monitor.
- One sub-module, sync_fifo: parameter AW, width 8, with wr/rd/full/empty/count ports and the same async active-high reset.
- The FSM, bit timer and shifter stay in serial_feeder.

Test Plan:
- Use CLKS_PER_BIT=4, CHAR_GAP=0, EOL_GAP=20. Push 8'h55 into an empty FIFO, then decode tx at mid-bit.
  - tx falls 2 clocks after wr.
  - Line reads 0,1,0,1,0,1,0,1,0,1 (start, LSB-first data, stop), 4 clocks per bit.
  - busy spans 40 clocks of frame plus gap.
- Push 16 bytes 8'h00..8'h0F on consecutive cycles with hold=1.
  - full=1 and count=16.
  - A 17th push of 8'hAA is dropped.
  - Release hold: the decoded stream is exactly 00..0F, and empty=1 after the last pop.
- Push 8'h0D then 8'h0A.
  - Idle-high time between the CR stop bit end and the LF start edge is 20 gap + 1 IDLE cycle.
  - The same measurement for 8'h41 followed by 8'h42 gives 1+1 cycles.
- Assert hold mid-data of byte 8'h3C with a second byte queued.
  - 8'h3C completes intact.
  - tx stays high while hold=1.
  - The second byte starts on the first IDLE cycle after hold drops.
- Assert reset during bit 3 of a frame with 5 bytes queued.
  - tx=1, count=0, empty=1, busy=0 immediately, with no clock edge required.
  - After release, a single push of 8'hC3 transmits correctly.
- At full, drive wr=1 in the same cycle the FSM pops.
  - count goes 16->15.
  - The pushed byte is not enqueued, confirmed by the decoded stream.
